// File: rtl/cache_param.sv
// Parameterised write-back cache (1- or 2-way, 4-word lines) with a
// three-state miss handler. Hits resolve combinationally; misses stall,
// optionally write back a dirty victim, then refill from memory.
//
// state | meaning
// IDLE  | lookup; hits complete this cycle, a miss latches its victim
// WBACK | dirty victim line being written to memory, waiting mem_ready
// ALLOC | requested block being read from memory, waiting mem_ready
`timescale 1ns/1ps
module cache_param #(
  parameter int SETS      = 4,
  parameter int WAYS      = 2,
  parameter int READ_ONLY = 0
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WBACK, ALLOC} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  dirty_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [127:0]     data_q  [WAYS][SETS];
  logic [SETS-1:0]  lru_q;

  logic [WAY_W-1:0] v_way_q;
  logic [IDX_W-1:0] v_idx_q;
  logic [TAG_W-1:0] v_tag_q;

  logic [1:0]       req_word;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             eff_write;
  logic             eff_read;
  logic             req_active;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [127:0]     hit_line;
  logic [WAY_W-1:0] victim_way;
  logic             victim_dirty;
  logic             idle_hit;
  logic             miss_start;
  logic             fill;

  assign req_word = proc_addr[1:0];
  assign req_idx  = proc_addr[IDX_W+1:2];
  assign req_tag  = proc_addr[29:IDX_W+2];

  // A read-only cache treats writes as idle; read+write together is a write.
  assign eff_write  = proc_write && (READ_ONLY == 0);
  assign eff_read   = proc_read && !eff_write;
  assign req_active = eff_read || eff_write;

  // Tag compare across all ways of the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line   = data_q[hit_way][req_idx];
  assign proc_rdata = hit_line[{req_word, 5'b0} +: 32];

  // Victim: first invalid way, else the way the LRU bit points at.
  always_comb begin
    victim_way = '0;
    if (WAYS == 2) begin
      if (!valid_q[0][req_idx])
        victim_way = '0;
      else if (!valid_q[WAYS-1][req_idx])
        victim_way = WAY_W'(1);
      else
        victim_way = lru_q[req_idx];
    end
  end

  assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];

  assign idle_hit   = (state_q == IDLE) && req_active && hit;
  assign miss_start = (state_q == IDLE) && req_active && !hit;
  assign fill       = (state_q == ALLOC) && mem_ready;

  // Next-state and output decode; everything is forced quiet while in reset.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (miss_start) begin
          proc_stall = 1'b1;
          state_d    = victim_dirty ? WBACK : ALLOC;
        end
      end
      WBACK: begin
        proc_stall = 1'b1;
        if (READ_ONLY == 0) begin
          mem_write = 1'b1;
          mem_addr  = {tag_q[v_way_q][v_idx_q], v_idx_q};
          mem_wdata = data_q[v_way_q][v_idx_q];
        end
        if (mem_ready)
          state_d = ALLOC;
      end
      ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {v_tag_q, v_idx_q};
        if (mem_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (proc_reset) begin
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  // State register plus victim/request capture on miss entry.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= IDLE;
      v_way_q <= '0;
      v_idx_q <= '0;
      v_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        v_way_q <= victim_way;
        v_idx_q <= req_idx;
        v_tag_q <= req_tag;
      end
    end
  end

  // Line status bits: refill validates and cleans, write hit dirties.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      if (fill) begin
        valid_q[v_way_q][v_idx_q] <= 1'b1;
        dirty_q[v_way_q][v_idx_q] <= 1'b0;
      end
      if (idle_hit && eff_write)
        dirty_q[hit_way][req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until valid, so no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[v_way_q][v_idx_q]  <= v_tag_q;
      data_q[v_way_q][v_idx_q] <= mem_rdata;
    end
    if (idle_hit && eff_write)
      data_q[hit_way][req_idx][{req_word, 5'b0} +: 32] <= proc_wdata;
  end

  generate
    if (WAYS == 2) begin : g_lru
      // On any hit, point the set's LRU bit at the way that was not used.
      always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset)
          lru_q <= '0;
        else if (idle_hit)
          lru_q[req_idx] <= ~hit_way;
      end
    end else begin : g_no_lru
      assign lru_q = '0;
    end
  endgenerate

endmodule
